// File: rtl/loc_stack.sv
// LIFO of visited maze locations with an in-order path dump (bottom to top) over valid/ready.
// Optional sticky overflow/underflow flags are built when LOC_STACK_ERR_FLAGS_EN is defined.
module loc_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  input  logic             dumpStart,
  input  logic             dumpRdy,
  output logic             dumpValid,
  output logic [WIDTH-1:0] dumpData,
  output logic             dumpDone,
  output logic             busy,
  output logic             ovf,
  output logic             unf
);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       sp_q, sp_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     top_idx;
  logic [WIDTH-1:0]  mem [DEPTH];

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == (AW+1)'(DEPTH));
  assign count   = sp_q;
  assign top_idx = AW'(sp_q - (AW+1)'(1));
  assign top     = empty ? '0 : mem[top_idx];

  assign dumpValid = (state_q == DUMP);
  assign dumpData  = mem[rd_ptr_q];
  assign dumpDone  = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      sp_q     <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= dataIn;
  end

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    rd_ptr_d = rd_ptr_q;
    we       = 1'b0;
    waddr    = AW'(sp_q);
    if (clr) begin
      state_d = IDLE;
      sp_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push && pop && !empty) begin
            we    = 1'b1;
            waddr = top_idx;
          end else if (push) begin
            if (!full) begin
              we   = 1'b1;
              sp_d = sp_q + (AW+1)'(1);
            end
          end else if (pop) begin
            if (!empty) sp_d = sp_q - (AW+1)'(1);
          end
          if (dumpStart) begin
            state_d  = empty ? DONE : DUMP;
            rd_ptr_d = '0;
          end
        end
        DUMP: begin
          if (dumpRdy) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if ({1'b0, rd_ptr_q} == sp_q - (AW+1)'(1)) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef LOC_STACK_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic idle_op;

  // Push-only on full and pop-only on empty are the rejected operations.
  always_comb begin
    idle_op = (state_q == IDLE) && !clr;
    ovf_d   = clr ? 1'b0 : (ovf_q | (idle_op && push && !pop && full));
    unf_d   = clr ? 1'b0 : (unf_q | (idle_op && pop && !push && empty));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_loc_stack.sv
// Directed table-driven bench for loc_stack plus hand sequences for dump, fill and reset corners.
module tb_loc_stack;

  logic       clk, rst, push, pop, clr, dumpStart, dumpRdy;
  logic [7:0] dataIn, top, dumpData;
  logic [8:0] count;
  logic       empty, full, dumpValid, dumpDone, busy, ovf, unf;

`ifdef LOC_STACK_ERR_FLAGS_EN
  localparam int FLAGS = 1;
`else
  localparam int FLAGS = 0;
`endif

  int total = 0;
  int bad   = 0;

  loc_stack #(.WIDTH(8), .DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr), .dataIn(dataIn),
    .top(top), .count(count), .empty(empty), .full(full),
    .dumpStart(dumpStart), .dumpRdy(dumpRdy), .dumpValid(dumpValid),
    .dumpData(dumpData), .dumpDone(dumpDone), .busy(busy), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push, pop, clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] top;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input logic [7:0] pat, input int plen, input logic push_dur,
                          input string tag);
    int nb, done_cyc;
    bit done, stalled;
    logic [7:0] held;
    logic [7:0] ex[3];
    ex[0] = 8'h00; ex[1] = 8'h10; ex[2] = 8'h11;
    nb = 0; done = 0; done_cyc = -1; stalled = 0; held = '0;
    @(negedge clk); dumpStart = 1'b1;
    @(negedge clk); dumpStart = 1'b0;
    chk({tag, "_valid_latency"}, int'(dumpValid), 1);
    for (int c = 0; c < 40 && !done; c++) begin
      dumpRdy = (c < plen) ? pat[c[2:0]] : 1'b1;
      push    = push_dur;
      dataIn  = 8'h77;
      #1;
      if (dumpDone) begin
        done = 1; done_cyc = c;
      end else if (dumpValid) begin
        if (stalled) chk({tag, "_stall_hold"}, int'(dumpData), int'(held));
        if (dumpRdy) begin
          if (nb < 3) chk({tag, "_beat"}, int'(dumpData), int'(ex[nb]));
          nb++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = dumpData;
        end
      end
      if (!done) @(negedge clk);
    end
    push = 1'b0; dumpRdy = 1'b0;
    chk({tag, "_done_seen"}, int'(done), 1);
    chk({tag, "_beats"}, nb, 3);
    chk({tag, "_done_cycle"}, done_cyc, (plen == 0) ? 3 : 5);
    @(negedge clk);
    chk({tag, "_count_after"}, int'(count), 3);
    chk({tag, "_top_after"}, int'(top), 8'h11);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    clk = 0; rst = 0; push = 0; pop = 0; clr = 0; dataIn = '0;
    dumpStart = 0; dumpRdy = 0;

    v[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h00};
    v[1] = '{1'b1, 1'b0, 1'b0, 8'h01, 2, 8'h01};
    v[2] = '{1'b1, 1'b0, 1'b0, 8'h11, 3, 8'h11};
    v[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h01};
    v[4] = '{1'b1, 1'b1, 1'b0, 8'h21, 2, 8'h21};
    v[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h00};
    v[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00};
    v[7] = '{1'b1, 1'b1, 1'b0, 8'h05, 1, 8'h05};
    v[8] = '{1'b1, 1'b0, 1'b1, 8'h33, 0, 8'h00};
    v[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_top", int'(top), 0);
    chk("rst_valid", int'(dumpValid), 0);
    chk("rst_done", int'(dumpDone), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_unf", int'(unf), 0);
    rst = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      push = v[i].push; pop = v[i].pop; clr = v[i].clr; dataIn = v[i].din;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), int'(count), v[i].cnt);
      chk($sformatf("vec%0d_top", i), int'(top), int'(v[i].top));
      chk($sformatf("vec%0d_empty", i), int'(empty), (v[i].cnt == 0) ? 1 : 0);
    end
    @(negedge clk); push = 0; pop = 0; clr = 0;
    chk("unf_after_empty_pop", int'(unf), FLAGS);

    clr = 1;
    @(negedge clk); clr = 0;
    chk("unf_cleared", int'(unf), 0);

    for (int i = 0; i < 256; i++) begin
      push = 1; dataIn = 8'(i);
      @(negedge clk);
    end
    push = 0; #1;
    chk("fill_count", int'(count), 256);
    chk("fill_full", int'(full), 1);
    chk("fill_top", int'(top), 8'hFF);
    chk("fill_ovf_pre", int'(ovf), 0);
    push = 1; dataIn = 8'hAA;
    @(negedge clk); push = 0; #1;
    chk("ovf_count", int'(count), 256);
    chk("ovf_top", int'(top), 8'hFF);
    chk("ovf_flag", int'(ovf), FLAGS);
    clr = 1;
    @(negedge clk); clr = 0; #1;
    chk("clr_count", int'(count), 0);
    chk("clr_ovf", int'(ovf), 0);

    for (int i = 0; i < 3; i++) begin
      push = 1; dataIn = (i == 0) ? 8'h00 : (i == 1) ? 8'h10 : 8'h11;
      @(negedge clk);
    end
    push = 0;
    run_dump(8'h00, 0, 1'b0, "d1");
    run_dump(8'h00, 0, 1'b0, "d2");
    run_dump(8'b0001_1001, 5, 1'b1, "d3");

    @(negedge clk); dumpStart = 1; dumpRdy = 1;
    @(negedge clk); dumpStart = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("rst_mid_valid", int'(dumpValid), 0);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(dumpDone), 0);
    @(negedge clk); rst = 1; dumpRdy = 0;
    @(posedge clk); #1;
    chk("rst_mid_done_after", int'(dumpDone), 0);

    @(negedge clk); dumpStart = 1;
    @(posedge clk); #1;
    chk("empty_dump_done", int'(dumpDone), 1);
    chk("empty_dump_valid", int'(dumpValid), 0);
    @(negedge clk); dumpStart = 0;
    @(posedge clk); #1;
    chk("empty_dump_done_pulse", int'(dumpDone), 0);
    chk("empty_dump_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
